// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared types and constants for the instruction-memory loader
package instr_mem_loader_pkg;
   localparam int INSTR_W = 33;
   localparam int BYTES_PER_INSTR = 5;
   typedef enum logic [2:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_INSTR, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CNT  = 2'd1;
   localparam logic [1:0] ERR_PAD  = 2'd2;
   localparam logic [1:0] ERR_CSUM = 2'd3;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream, imem write port and load status of the loader
interface instr_mem_loader_if #(parameter int ADDR_W = 9);
   import instr_mem_loader_pkg::*;
   logic start;
   logic rx_valid;
   logic [7:0] rx_data;
   logic rx_ready;
   logic imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic core_hold;
   logic load_done;
   logic load_err;
   logic [1:0] err_code;
   logic [ADDR_W:0] words_loaded;
   modport master (
      output start, rx_valid, rx_data,
      input rx_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err, err_code, words_loaded
   );
   modport slave (
      input start, rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err, err_code, words_loaded
   );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// instr_mem_loader_byte_packer: shifts five bytes MSB-first into a 33-bit instruction
module instr_mem_loader_byte_packer
   import instr_mem_loader_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic push,
   input  logic [7:0] data,
   output logic [INSTR_W-1:0] word,
   output logic pad_bad,
   output logic full
);
   logic [2:0] idx;
   assign pad_bad = push && idx == 3'd0 && data[7:1] != 7'd0;
   assign full = push && idx == 3'(BYTES_PER_INSTR - 1);
   // five 8-bit shifts push out everything but bit0 of byte0, which lands in bit32
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         word <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (push && !pad_bad) begin
         word <= {word[INSTR_W-9:0], data};
         idx <= idx + 3'd1;
      end
   end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a checksummed byte stream into instruction-memory writes
// and holds the core until a complete verified image is present.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 9
)(
   input logic clk,
   input logic rst,
   instr_mem_loader_if.slave bus
);
   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
   state_t state, state_n;
   logic [15:0] n;
   logic [15:0] cnt_val;
   logic [ADDR_W:0] words;
   logic [ADDR_W:0] words_inc;
   logic [7:0] csum;
   logic [1:0] err, err_n;
   logic xfer, start_ok, pad_bad, full, cnt_big;
   logic [INSTR_W-1:0] word;
   assign start_ok = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign bus.rx_ready = state inside {S_CNT_HI, S_CNT_LO, S_INSTR, S_CHECK};
   assign xfer = bus.rx_valid && bus.rx_ready;
   assign cnt_val = {n[15:8], bus.rx_data};
   assign cnt_big = {1'b0, cnt_val} > DEPTH;
   assign words_inc = words + 1'b1;
   instr_mem_loader_byte_packer u_packer (
      .clk(clk),
      .rst(rst),
      .clr(state == S_WRITE || start_ok),
      .push(xfer && state == S_INSTR),
      .data(bus.rx_data),
      .word(word),
      .pad_bad(pad_bad),
      .full(full)
   );
   always_comb begin
      state_n = state;
      err_n = start_ok ? ERR_NONE : err;
      case (state)
         S_IDLE, S_DONE, S_ERROR: state_n = start_ok ? S_CNT_HI : state;
         S_CNT_HI: state_n = xfer ? S_CNT_LO : state;
         S_CNT_LO: begin
            state_n = !xfer ? state : cnt_big ? S_ERROR : cnt_val == 16'd0 ? S_CHECK : S_INSTR;
            err_n = xfer && cnt_big ? ERR_CNT : err;
         end
         S_INSTR: begin
            state_n = pad_bad ? S_ERROR : full ? S_WRITE : state;
            err_n = pad_bad ? ERR_PAD : err;
         end
         S_WRITE: state_n = 16'(words_inc) == n ? S_CHECK : S_INSTR;
         S_CHECK: begin
            state_n = !xfer ? state : bus.rx_data == csum ? S_DONE : S_ERROR;
            err_n = xfer && bus.rx_data != csum ? ERR_CSUM : err;
         end
         default: state_n = S_IDLE;
      endcase
   end
   // the checksum byte itself is excluded from the running XOR
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         n <= '0;
         words <= '0;
         csum <= '0;
         err <= ERR_NONE;
      end else begin
         state <= state_n;
         err <= err_n;
         if (start_ok) begin
            n <= '0;
            words <= '0;
            csum <= '0;
         end else begin
            if (xfer && state != S_CHECK) csum <= csum ^ bus.rx_data;
            if (xfer && state == S_CNT_HI) n[15:8] <= bus.rx_data;
            if (xfer && state == S_CNT_LO) n[7:0] <= bus.rx_data;
            if (state == S_WRITE) words <= words_inc;
         end
      end
   end
   assign bus.imem_we = state == S_WRITE;
   assign bus.imem_addr = words[ADDR_W-1:0];
   assign bus.imem_wdata = word;
   assign bus.core_hold = state != S_DONE;
   assign bus.load_done = state == S_DONE;
   assign bus.load_err = state == S_ERROR;
   assign bus.err_code = err;
   assign bus.words_loaded = words;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: random and directed frames checked against a byte-level frame interpreter
module tb_instr_mem_loader;
   localparam int ADDR_W = 9;
   localparam int DEPTH = 512;
   typedef logic [7:0] bq_t[$];
   typedef logic [32:0] wq_t[$];
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [ADDR_W-1:0] wr_a[$];
   logic [32:0] wr_d[$];
   always #5 clk = ~clk;
   instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus();
   instr_mem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_a.push_back(bus.imem_addr);
         wr_d.push_back(bus.imem_wdata);
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic bq_t build(input wq_t w);
      bq_t b;
      logic [7:0] cs;
      logic [15:0] n;
      n = 16'(w.size());
      b.push_back(n[15:8]);
      b.push_back(n[7:0]);
      foreach (w[k]) begin
         b.push_back({7'd0, w[k][32]});
         b.push_back(w[k][31:24]);
         b.push_back(w[k][23:16]);
         b.push_back(w[k][15:8]);
         b.push_back(w[k][7:0]);
      end
      cs = 8'd0;
      foreach (b[k]) cs ^= b[k];
      b.push_back(cs);
      return b;
   endfunction
   // walks the frame as the format describes it: bytes consumed, words written, error code
   task automatic model(input bq_t fb, output int cons, output wq_t ew, output logic [1:0] ec);
      int n;
      logic [7:0] cs;
      ew = {};
      n = int'({fb[0], fb[1]});
      cs = fb[0] ^ fb[1];
      cons = 2;
      if (n > DEPTH) begin
         ec = 2'd1;
         return;
      end
      for (int w = 0; w < n; w++) begin
         if (fb[cons][7:1] != 7'd0) begin
            cons++;
            ec = 2'd2;
            return;
         end
         ew.push_back({fb[cons][0], fb[cons+1], fb[cons+2], fb[cons+3], fb[cons+4]});
         for (int k = 0; k < 5; k++) cs ^= fb[cons+k];
         cons += 5;
      end
      ec = fb[cons] == cs ? 2'd0 : 2'd3;
      cons++;
   endtask
   task automatic do_start(input logic [7:0] first);
      @(negedge clk);
      bus.start = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data = first;
      chk("start_no_ready", 64'(bus.rx_ready), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.rx_valid = 1'b0;
      chk("hold_after_start", 64'(bus.core_hold), 64'd1);
      chk("ready_after_start", 64'(bus.rx_ready), 64'd1);
   endtask
   task automatic send(input bq_t fb, input int nb, input int nw, input int mode, input bit inject);
      int i = 0;
      int stall = 0;
      bit last = 1'b0;
      bit tog = 1'b0;
      bit v;
      while (i < nb && stall <= 200) begin
         @(negedge clk);
         if (last) chk("we_latency", 64'(bus.imem_we), 64'd1);
         last = 1'b0;
         tog = !tog;
         v = mode == 0 || (mode == 1 && tog) || (mode == 2 && $urandom_range(0, 3) != 0);
         bus.rx_valid = v;
         bus.rx_data = v ? fb[i] : 8'($urandom);
         bus.start = inject && i == 7;
         if (v && bus.rx_ready) begin
            last = i >= 2 && i < 2 + 5 * nw && (i - 2) % 5 == 4;
            i++;
            stall = 0;
         end else begin
            stall++;
         end
      end
      @(negedge clk);
      if (last) chk("we_latency", 64'(bus.imem_we), 64'd1);
      bus.rx_valid = 1'b0;
      bus.start = 1'b0;
      chk("bytes_sent", 64'(i), 64'(nb));
   endtask
   task automatic check_writes(input wq_t ew);
      chk("n_writes", 64'(wr_a.size()), 64'(ew.size()));
      foreach (ew[k]) begin
         if (k < wr_a.size()) begin
            chk("wr_addr", 64'(wr_a[k]), 64'(k));
            chk("wr_data", 64'(wr_d[k]), 64'(ew[k]));
         end
      end
   endtask
   task automatic run_frame(input bq_t fb, input int mode, input bit inject);
      int cons;
      wq_t ew;
      logic [1:0] ec;
      model(fb, cons, ew, ec);
      wr_a.delete();
      wr_d.delete();
      do_start(fb[0]);
      send(fb, cons, ew.size(), mode, inject);
      repeat (2) @(negedge clk);
      check_writes(ew);
      chk("load_done", 64'(bus.load_done), 64'(ec == 2'd0));
      chk("load_err", 64'(bus.load_err), 64'(ec != 2'd0));
      chk("err_code", 64'(bus.err_code), 64'(ec));
      chk("core_hold", 64'(bus.core_hold), 64'(ec != 2'd0));
      chk("words_loaded", 64'(bus.words_loaded), 64'(ew.size()));
      chk("ready_idle", 64'(bus.rx_ready), 64'd0);
   endtask
   function automatic wq_t rand_words(input int n);
      wq_t w;
      for (int k = 0; k < n; k++) w.push_back({1'($urandom), 32'($urandom)});
      return w;
   endfunction
   initial begin
      bq_t fb;
      wq_t w;
      int n, kind, k;
      bus.start = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_hold", 64'(bus.core_hold), 64'd1);
      chk("rst_done", 64'(bus.load_done), 64'd0);
      chk("rst_err", 64'(bus.load_err), 64'd0);
      chk("rst_code", 64'(bus.err_code), 64'd0);
      chk("rst_words", 64'(bus.words_loaded), 64'd0);
      chk("rst_ready", 64'(bus.rx_ready), 64'd0);
      chk("rst_we", 64'(bus.imem_we), 64'd0);
      chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
      w = {33'h1_FF00AABB};
      run_frame(build(w), 0, 1'b0);
      if (wr_d.size() > 0) chk("t1_word", 64'(wr_d[0]), 64'h1_FF00AABB);
      run_frame(build(rand_words(3)), 1, 1'b0);
      fb = {8'h02, 8'h01};
      run_frame(fb, 0, 1'b0);
      fb = build(rand_words(3));
      fb[7] = 8'h03;
      run_frame(fb, 2, 1'b0);
      fb = build(rand_words(3));
      fb[fb.size()-1] = fb[fb.size()-1] + 8'd1;
      run_frame(fb, 2, 1'b0);
      w = rand_words(3);
      fb = build(w);
      wr_a.delete();
      wr_d.delete();
      do_start(fb[0]);
      send(fb, 15, 3, 2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      w = w[0:1];
      check_writes(w);
      chk("rst_mid_hold", 64'(bus.core_hold), 64'd1);
      chk("rst_mid_ready", 64'(bus.rx_ready), 64'd0);
      chk("rst_mid_words", 64'(bus.words_loaded), 64'd0);
      run_frame(build(rand_words(4)), 2, 1'b1);
      fb = {8'h00, 8'h00, 8'h00};
      run_frame(fb, 0, 1'b0);
      run_frame(fb, 1, 1'b0);
      run_frame(build(rand_words(DEPTH)), 0, 1'b0);
      for (int it = 0; it < 12; it++) begin
         n = $urandom_range(1, 6);
         fb = build(rand_words(n));
         kind = $urandom_range(0, 3);
         if (kind == 1) begin
            k = 2 + 5 * $urandom_range(0, n - 1);
            fb[k] = fb[k] | 8'($urandom_range(1, 127) << 1);
         end else if (kind == 2) begin
            fb[fb.size()-1] = fb[fb.size()-1] ^ 8'($urandom_range(1, 255));
         end else if (kind == 3) begin
            fb[0] = 8'($urandom_range(3, 255));
         end
         run_frame(fb, $urandom_range(0, 2), 1'b1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
